data_ram_responder: RTL and testbench

//  Data-memory responder on the ID-stage load/store RAM interface. It accepts one

---
 rtl/data_ram_responder.sv | 172 +++++++++++++++++
 tb/tb_data_ram_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_responder.sv
// Purpose: data-memory responder for the ID-stage load/store RAM port, backed by an internal word RAM.
// Latency: request accepted at edge t, ram_ready pulses during cycle t+1+WAIT_CYCLES; one request per 2+WAIT_CYCLES cycles.
// Backpressure: stall_req holds the pipeline while a request is outstanding; ram_en seen in RESP waits for the next IDLE cycle.
module data_ram_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_en,
  input  logic        ram_write_en,
  input  logic [3:0]  ram_write_sel,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_write_data,
  output logic [31:0] ram_read_data,
  output logic        ram_ready,
  output logic        misalign_err,
  output logic        stall_req
);

  localparam int          DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;

  // Captured request (only the address bits that matter are kept)
  logic                    r_we;
  logic [3:0]              r_sel;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic                    r_mis;
  logic [31:0]             r_wdata;

  logic [31:0]             r_mem [DEPTH];
  logic [31:0]             r_rdata;
  logic                    r_misalign_err;

  logic                    w_accept;
  logic                    w_enter_resp;

  // Request actually serviced on the RESP transition edge
  logic                    w_req_we;
  logic [3:0]              w_req_sel;
  logic [DEPTH_LOG2-1:0]   w_req_idx;
  logic                    w_req_mis;
  logic [31:0]             w_req_wdata;

  logic [DEPTH_LOG2-1:0]   w_in_idx;
  logic                    w_in_mis;
  logic                    w_unused_addr;

  // Upper address bits are ignored so out-of-range addresses wrap onto the RAM
  assign w_in_idx      = ram_addr[DEPTH_LOG2+1:2];
  assign w_in_mis      = |ram_addr[1:0];
  assign w_unused_addr = ^ram_addr[31:DEPTH_LOG2+2];

  // With zero wait states RESP is entered straight from IDLE, so the live inputs
  // are serviced; otherwise the request captured at accept time is used.
  assign w_req_we    = (r_state == S_IDLE) ? ram_write_en   : r_we;
  assign w_req_sel   = (r_state == S_IDLE) ? ram_write_sel  : r_sel;
  assign w_req_idx   = (r_state == S_IDLE) ? w_in_idx       : r_idx;
  assign w_req_mis   = (r_state == S_IDLE) ? w_in_mis       : r_mis;
  assign w_req_wdata = (r_state == S_IDLE) ? ram_write_data : r_wdata;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode, accept/commit strobes and the pipeline stall
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    stall_req    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ram_en) begin
          stall_req = 1'b1;
          w_accept  = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_next       = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall_req = 1'b1;
        if (r_cnt <= 4'd1) begin
          w_next       = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Wait-state counter: loaded on accept, counts down while waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= LP_WAIT;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Capture the request on accept; later input changes are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_sel   <= 4'd0;
      r_idx   <= '0;
      r_mis   <= 1'b0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_we    <= ram_write_en;
      r_sel   <= ram_write_sel;
      r_idx   <= w_in_idx;
      r_mis   <= w_in_mis;
      r_wdata <= ram_write_data;
    end
  end

  // Byte-lane write commit on the RESP transition edge; RAM contents survive reset
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_req_we && !w_req_mis) begin
      for (int b = 0; b < 4; b++) begin
        if (w_req_sel[b]) begin
          r_mem[w_req_idx][8*b +: 8] <= w_req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response data and alignment flag, registered on the RESP transition edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata        <= 32'd0;
      r_misalign_err <= 1'b0;
    end else if (w_enter_resp) begin
      r_rdata        <= (!w_req_we && !w_req_mis) ? r_mem[w_req_idx] : 32'd0;
      r_misalign_err <= w_req_mis;
    end else begin
      r_misalign_err <= 1'b0;
    end
  end

  assign ram_read_data = r_rdata;
  assign ram_ready     = (r_state == S_RESP);
  assign misalign_err  = r_misalign_err;

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: one instance with one wait state, one with none.
// Requests push their expected response into a per-instance queue; monitors pop on ram_ready.
// Inputs are driven on the falling edge, outputs sampled on the falling edge or 1ns after it.
module tb_data_ram_responder;

  typedef struct packed {
    logic [31:0] d;
    logic        m;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        cur;   // 1 selects the one-wait-state instance, 0 the zero-wait instance
  logic        en;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wd;

  logic [31:0] rd1, rd0;
  logic        rdy1, rdy0, mis1, mis0, st1, st0;

  exp_t q1[$];
  exp_t q0[$];

  int n_cmp = 0;
  int n_bad = 0;

  data_ram_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_w1 (
    .clk            (clk),
    .rst            (rst),
    .ram_en         (en & cur),
    .ram_write_en   (we),
    .ram_write_sel  (sel),
    .ram_addr       (addr),
    .ram_write_data (wd),
    .ram_read_data  (rd1),
    .ram_ready      (rdy1),
    .misalign_err   (mis1),
    .stall_req      (st1)
  );

  data_ram_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
    .clk            (clk),
    .rst            (rst),
    .ram_en         (en & ~cur),
    .ram_write_en   (we),
    .ram_write_sel  (sel),
    .ram_addr       (addr),
    .ram_write_data (wd),
    .ram_read_data  (rd0),
    .ram_ready      (rdy0),
    .misalign_err   (mis0),
    .stall_req      (st0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Scoreboard monitor, one-wait-state instance
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rdy1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready_w1: ram_ready=1 with no request pending (t=%0t)", $time);
      end else begin
        e = q1.pop_front();
        chk("rdata_w1", rd1, e.d);
        chk("misalign_w1", {31'b0, mis1}, {31'b0, e.m});
        chk("stall_in_resp_w1", {31'b0, st1}, 32'd0);
      end
    end
  end

  // Scoreboard monitor, zero-wait instance
  always @(negedge clk) begin : mon0
    exp_t e;
    if (rdy0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready_w0: ram_ready=1 with no request pending (t=%0t)", $time);
      end else begin
        e = q0.pop_front();
        chk("rdata_w0", rd0, e.d);
        chk("misalign_w0", {31'b0, mis0}, {31'b0, e.m});
        chk("stall_in_resp_w0", {31'b0, st0}, 32'd0);
      end
    end
  end

  // One request: drive it, queue its expected response, measure latency and stall length
  task automatic req(input logic d, input logic w, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] wdat, input logic [31:0] exp_d, input logic exp_m);
    int   lat;
    int   stc;
    exp_t e;
    @(negedge clk);
    cur  = d;
    en   = 1'b1;
    we   = w;
    sel  = s;
    addr = a;
    wd   = wdat;
    e.d  = exp_d;
    e.m  = exp_m;
    if (d) q1.push_back(e);
    else   q0.push_back(e);
    #1;
    lat = 0;
    stc = 0;
    while (((d ? rdy1 : rdy0) !== 1'b1) && lat < 20) begin
      if ((d ? st1 : st0) === 1'b1) stc++;
      @(negedge clk);
      en = 1'b0;
      #1;
      lat++;
    end
    chk(d ? "latency_w1" : "latency_w0", 32'(lat), d ? 32'd2 : 32'd1);
    chk(d ? "stall_cycles_w1" : "stall_cycles_w0", 32'(stc), d ? 32'd2 : 32'd1);
  endtask

  task automatic push1(input logic [31:0] d);
    exp_t e;
    e.d = d;
    e.m = 1'b0;
    q1.push_back(e);
  endtask

  initial begin : stim
    int guard;
    rst  = 1'b0;
    cur  = 1'b1;
    en   = 1'b0;
    we   = 1'b0;
    sel  = 4'd0;
    addr = 32'd0;
    wd   = 32'd0;

    // Reset state of both instances
    #12;
    chk("rst_rdata_w1", rd1, 32'd0);
    chk("rst_ready_w1", {31'b0, rdy1}, 32'd0);
    chk("rst_mis_w1", {31'b0, mis1}, 32'd0);
    chk("rst_stall_w1", {31'b0, st1}, 32'd0);
    chk("rst_rdata_w0", rd0, 32'd0);
    chk("rst_ready_w0", {31'b0, rdy0}, 32'd0);
    chk("rst_mis_w0", {31'b0, mis0}, 32'd0);
    chk("rst_stall_w0", {31'b0, st0}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Full-word write then read back
    req(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    req(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    #1;
    chk("rdata_hold_w1", rd1, 32'hDEADBEEF);
    chk("ready_low_after_resp_w1", {31'b0, rdy1}, 32'd0);

    // Byte-lane writes, including an empty lane mask
    req(1'b1, 1'b1, 4'b0001, 32'h10, 32'h000000AA, 32'h0, 1'b0);
    req(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEAA, 1'b0);
    req(1'b1, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b0);
    req(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEAA, 1'b0);
    req(1'b1, 1'b1, 4'b1000, 32'h10, 32'h77000000, 32'h0, 1'b0);
    req(1'b1, 1'b1, 4'b0110, 32'h10, 32'h00CDEF00, 32'h0, 1'b0);
    req(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 32'h77CDEFAA, 1'b0);

    // Misaligned read and write: flagged, no RAM access
    req(1'b1, 1'b0, 4'hF, 32'h13, 32'h0, 32'h0, 1'b1);
    req(1'b1, 1'b1, 4'hF, 32'h11, 32'h12345678, 32'h0, 1'b1);
    req(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 32'h77CDEFAA, 1'b0);

    // Zero wait states and address aliasing above the RAM depth
    req(1'b0, 1'b1, 4'hF, 32'h0, 32'h00001234, 32'h0, 1'b0);
    req(1'b0, 1'b0, 4'hF, 32'h1000, 32'h0, 32'h00001234, 1'b0);
    req(1'b0, 1'b1, 4'hF, 32'h80001004, 32'hCAFEF00D, 32'h0, 1'b0);
    req(1'b0, 1'b0, 4'hF, 32'h4, 32'h0, 32'hCAFEF00D, 1'b0);

    // Reset during the wait state of a write discards it
    req(1'b1, 1'b1, 4'hF, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
    req(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);
    @(negedge clk);
    cur  = 1'b1;
    en   = 1'b1;
    we   = 1'b1;
    sel  = 4'hF;
    addr = 32'h20;
    wd   = 32'h00000055;
    @(negedge clk);
    en = 1'b0;
    #1;
    chk("wait_stall_before_rst", {31'b0, st1}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_rdata", rd1, 32'd0);
    chk("midrst_ready", {31'b0, rdy1}, 32'd0);
    chk("midrst_mis", {31'b0, mis1}, 32'd0);
    chk("midrst_stall", {31'b0, st1}, 32'd0);
    @(negedge clk);
    #1;
    chk("midrst_ready_later", {31'b0, rdy1}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);

    // ram_en held across RESP with the address changing during WAIT
    req(1'b1, 1'b1, 4'hF, 32'h40, 32'h11111111, 32'h0, 1'b0);
    req(1'b1, 1'b1, 4'hF, 32'h44, 32'h22222222, 32'h0, 1'b0);
    @(negedge clk);
    cur  = 1'b1;
    en   = 1'b1;
    we   = 1'b0;
    sel  = 4'hF;
    addr = 32'h40;
    push1(32'h11111111);
    #1;
    chk("held_accept_stall", {31'b0, st1}, 32'd1);
    @(negedge clk);
    addr = 32'h44;
    push1(32'h22222222);
    #1;
    chk("held_wait_stall", {31'b0, st1}, 32'd1);
    chk("held_wait_ready", {31'b0, rdy1}, 32'd0);
    @(negedge clk);
    #1;
    chk("held_first_ready", {31'b0, rdy1}, 32'd1);
    chk("held_resp_no_stall", {31'b0, st1}, 32'd0);
    @(negedge clk);
    #1;
    chk("held_idle_ready", {31'b0, rdy1}, 32'd0);
    chk("held_idle_stall", {31'b0, st1}, 32'd1);
    @(negedge clk);
    en = 1'b0;
    #1;
    chk("held2_wait_stall", {31'b0, st1}, 32'd1);
    chk("held2_wait_ready", {31'b0, rdy1}, 32'd0);
    @(negedge clk);
    #1;
    chk("held2_ready", {31'b0, rdy1}, 32'd1);

    // Drain and confirm every expected response was seen
    guard = 0;
    while ((q1.size() != 0 || q0.size() != 0) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    chk("pending_w1", 32'(q1.size()), 32'd0);
    chk("pending_w0", 32'(q0.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got %0d mismatches so far, expected completion", n_bad);
    $fatal(1, "timeout");
  end

endmodule
